tdc_coarse_counter_mc: RTL
==========================

Name: tdc_coarse_counter_mc

Overview:
- Multi-channel, parametrised coarse (integer-clock) interval counter for the TDC.
- Each channel measures clk edges from a start pulse to a stop pulse; fixes the off-by-one of the previous single-channel counter.
- Results are merged through a round-robin arbiter into one valid/ready result stream.
- Sits between the start/stop synchronisers and the result FIFO / fine-code combiner.

Parameters:
- N_CH, 4, number of independent channels (1..16).
- CNT_W, 6, coarse code width; full scale 2^CNT_W-1.
- DROP_W, 16, width of the dropped-event counter (optional feature only).
- CH_W, $clog2(N_CH) (min 1), localparam; channel index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous soft clear; all channels to IDLE, output register emptied.
- start  in  N_CH  per-channel start pulse; synchronous, sampled on posedge.
- stop  in  N_CH  per-channel stop pulse; synchronous, sampled on posedge.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_chan  out  CH_W  channel index of result.
- out_code  out  CNT_W  coarse interval in clk periods.
- out_ovf  out  1  measurement timed out; code saturated.
- out_coinc  out  1  start and stop sampled on the same edge.
- busy  out  N_CH  per-channel: channel is not IDLE.

Behaviour:
- Reset (rst low): all channels IDLE, counters 0, out_valid/out_chan/out_code/out_ovf/out_coinc 0, busy 0, arbiter pointer 0. clr has the same effect synchronously, with priority over all other inputs.
- Per-channel FSM, states IDLE, RUN, DONE:
  - IDLE + start only: ctr<=0, go RUN.
  - IDLE + start + stop: result code=0, coinc=1, go DONE.
  - IDLE + stop only: ignored.
  - RUN, no stop: ctr<=ctr+1.
  - RUN + stop: result code=ctr+1, go DONE. For start at edge E0 and stop at edge E1, code = E1-E0 exactly.
  - RUN + start, no stop: re-arm, ctr<=0; prior interval discarded.
  - RUN + start + stop: stop wins, result captured, start ignored.
  - RUN timeout: if ctr+1 == 2^CNT_W-1 with no stop, result code=2^CNT_W-1, ovf=1, go DONE. A stop on that same edge gives code=2^CNT_W-1, ovf=0.
  - DONE: result held; start/stop ignored and counted as drops. Go IDLE on the edge the result is loaded into the output register. Start/stop on that same edge are also dropped.
- Arbiter and output register:
  - Output register loads when !out_valid || out_ready.
  - Among DONE channels, selects the first at or after rr_ptr; rr_ptr <= selected+1 (mod N_CH) on load.
  - Latency: stop sampled at edge E, output free → out_valid high after edge E+1.
  - Back-to-back results are sustained at one per cycle while out_ready is high.
- Handshake: transfer occurs when out_valid && out_ready. While out_valid && !out_ready, all out_* are held stable.
- busy[i] = channel i state != IDLE, registered.
- Reset mid-operation: everything aborts immediately; no partial result is emitted.

Optional Feature:
- Macro: TDC_DROP_CNT_EN.
- When defined:
  - Extra output port drop_cnt [DROP_W-1:0].
  - Increments by the number of channels that drop an event on a given edge (start or stop in DONE, at most one count per channel per edge).
  - Saturates at all-ones; cleared by rst and clr.
- When undefined: port and logic absent; drops are silent.

Decomposition:
- Package tdc_pkg:
  - chan_state_t enum {IDLE, RUN, DONE}.
  - tdc_result_t packed struct {code, ovf, coinc}, parameterised by CNT_W via a package localparam default.
- Sub-module tdc_coarse_chan: one FSM + counter + result register per channel.
  - Inputs: start, stop, take, clr.
  - Outputs: done, result, busy, drop.
  - Top instantiates N_CH of these plus the arbiter and output register.

Test Plan (N_CH=4, CNT_W=6):
- ch0 start at edge 10, stop at edge 15, out_ready=1 → out_valid after edge 16 for 1 cycle; chan=0, code=5, ovf=0, coinc=0.
- ch1 start+stop same edge 20 → chan=1, code=0, coinc=1, ovf=0.
- ch2 start at edge 30, no stop → at edge 93 result captured; chan=2, code=63, ovf=1. Stop at edge 93 instead → code=63, ovf=0.
- ch0 and ch3 stop same edge, out_ready low for 5 cycles → chan=0 result held stable for 5 cycles; ch3 (code per its start) follows on the next cycle after the handshake; rr_ptr=0 after.
- ch0 in DONE with out_ready low; pulse start then stop on ch0 → both ignored; with TDC_DROP_CNT_EN, drop_cnt=2. Emitted ch0 code is unchanged.
- ch1 in RUN with ctr=12, assert rst low 1 cycle → all outputs 0, busy=0. A subsequent stop on ch1 produces no result; clr in RUN behaves identically.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared types for the multi-channel coarse TDC counter.
// Result vectors are laid out as {code, ovf, coinc}, matching tdc_result_t.
package tdc_pkg;

    localparam int TDC_CNT_W     = 6;
    localparam int RES_COINC_BIT = 0;
    localparam int RES_OVF_BIT   = 1;
    localparam int RES_CODE_LSB  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chan_state_t;

    typedef struct packed {
        logic [TDC_CNT_W-1:0] code;
        logic                 ovf;
        logic                 coinc;
    } tdc_result_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdc_coarse_chan.sv
// One coarse-counter channel: IDLE/RUN/DONE FSM, interval counter and held result.
// Optional TDC_DROP_CNT_EN adds a per-edge drop flag for events arriving while DONE.
module tdc_coarse_chan
    import tdc_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             start,
    input  logic             stop,
    input  logic             take,
    output logic             done,
    output logic [CNT_W+1:0] result,
    output logic             busy
`ifdef TDC_DROP_CNT_EN
    ,
    output logic             drop
`endif
);

    localparam logic [CNT_W-1:0] FULL = '1;

    chan_state_t      state_q, state_d;
    logic [CNT_W-1:0] ctr_q, ctr_d;
    logic [CNT_W-1:0] code_q, code_d;
    logic             ovf_q, ovf_d;
    logic             coinc_q, coinc_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] ctr_inc;

    // ctr holds (edges since start - 1), so ctr+1 is the exact interval on the stop edge
    assign ctr_inc = ctr_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        code_d  = code_q;
        ovf_d   = ovf_q;
        coinc_d = coinc_q;
        if (clr) begin
            state_d = IDLE;
            ctr_d   = '0;
            code_d  = '0;
            ovf_d   = 1'b0;
            coinc_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && stop) begin
                        code_d  = '0;
                        ovf_d   = 1'b0;
                        coinc_d = 1'b1;
                        state_d = DONE;
                    end else if (start) begin
                        ctr_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        code_d  = ctr_inc;
                        ovf_d   = 1'b0;
                        coinc_d = 1'b0;
                        state_d = DONE;
                    end else if (start) begin
                        ctr_d = '0;
                    end else if (ctr_inc == FULL) begin
                        code_d  = FULL;
                        ovf_d   = 1'b1;
                        coinc_d = 1'b0;
                        state_d = DONE;
                    end else begin
                        ctr_d = ctr_inc;
                    end
                end
                DONE: begin
                    if (take) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ctr_q   <= '0;
            code_q  <= '0;
            ovf_q   <= 1'b0;
            coinc_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            code_q  <= code_d;
            ovf_q   <= ovf_d;
            coinc_q <= coinc_d;
            busy_q  <= busy_d;
        end
    end

    assign done   = (state_q == DONE);
    assign result = {code_q, ovf_q, coinc_q};
    assign busy   = busy_q;

`ifdef TDC_DROP_CNT_EN
    assign drop = (state_q == DONE) && (start || stop);
`endif

endmodule

// File: rtl/tdc_coarse_counter_mc.sv
// N_CH coarse interval counters merged by a round-robin arbiter into one valid/ready stream.
// Define TDC_DROP_CNT_EN to add the saturating drop_cnt output.
module tdc_coarse_counter_mc
    import tdc_pkg::*;
#(
    parameter  int N_CH   = 4,
    parameter  int CNT_W  = 6,
    parameter  int DROP_W = 16,
    localparam int CH_W   = ch_width(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [N_CH-1:0]   start,
    input  logic [N_CH-1:0]   stop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_chan,
    output logic [CNT_W-1:0]  out_code,
    output logic              out_ovf,
    output logic              out_coinc,
    output logic [N_CH-1:0]   busy
`ifdef TDC_DROP_CNT_EN
    ,
    output logic [DROP_W-1:0] drop_cnt
`endif
);

    if (N_CH < 1 || N_CH > 16 || CNT_W < 1 || DROP_W < 5) begin : g_bad_cfg
        $error("tdc_coarse_counter_mc: unsupported parameter set");
    end

    logic [N_CH-1:0]  done_vec;
    logic [N_CH-1:0]  take_vec;
    logic [N_CH-1:0]  busy_vec;
    logic [CNT_W+1:0] res_vec [N_CH];
`ifdef TDC_DROP_CNT_EN
    logic [N_CH-1:0]  drop_vec;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_chan
            tdc_coarse_chan #(
                .CNT_W(CNT_W)
            ) u_chan (
                .clk    (clk),
                .rst    (rst),
                .clr    (clr),
                .start  (start[gi]),
                .stop   (stop[gi]),
                .take   (take_vec[gi]),
                .done   (done_vec[gi]),
                .result (res_vec[gi]),
                .busy   (busy_vec[gi])
`ifdef TDC_DROP_CNT_EN
                ,
                .drop   (drop_vec[gi])
`endif
            );
        end
    endgenerate

    assign busy = busy_vec;

    logic              out_valid_q, out_valid_d;
    logic [CH_W-1:0]   out_chan_q, out_chan_d;
    logic [CNT_W-1:0]  out_code_q, out_code_d;
    logic              out_ovf_q, out_ovf_d;
    logic              out_coinc_q, out_coinc_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              any_done;
    logic [CH_W-1:0]   sel;
    logic              load;

    // First DONE channel scanning upward from rr_ptr with wrap-around
    always_comb begin
        any_done = 1'b0;
        sel      = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (!any_done && done_vec[(int'(rr_ptr_q) + k) % N_CH]) begin
                any_done = 1'b1;
                sel      = CH_W'((int'(rr_ptr_q) + k) % N_CH);
            end
        end
    end

    assign load = !out_valid_q || out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_chan_d  = out_chan_q;
        out_code_d  = out_code_q;
        out_ovf_d   = out_ovf_q;
        out_coinc_d = out_coinc_q;
        rr_ptr_d    = rr_ptr_q;
        take_vec    = '0;
        if (clr) begin
            out_valid_d = 1'b0;
            out_chan_d  = '0;
            out_code_d  = '0;
            out_ovf_d   = 1'b0;
            out_coinc_d = 1'b0;
            rr_ptr_d    = '0;
        end else if (load) begin
            if (any_done) begin
                take_vec[sel] = 1'b1;
                out_valid_d   = 1'b1;
                out_chan_d    = sel;
                out_code_d    = res_vec[sel][CNT_W+1:RES_CODE_LSB];
                out_ovf_d     = res_vec[sel][RES_OVF_BIT];
                out_coinc_d   = res_vec[sel][RES_COINC_BIT];
                rr_ptr_d      = (sel == CH_W'(N_CH - 1)) ? '0 : sel + CH_W'(1);
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_code_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_coinc_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
            out_code_q  <= out_code_d;
            out_ovf_q   <= out_ovf_d;
            out_coinc_q <= out_coinc_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;
    assign out_code  = out_code_q;
    assign out_ovf   = out_ovf_q;
    assign out_coinc = out_coinc_q;

`ifdef TDC_DROP_CNT_EN
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [DROP_W:0]   drop_sum;

    // One extra MSB catches the carry so the counter can saturate instead of wrapping
    always_comb begin
        drop_sum = {1'b0, drop_cnt_q};
        for (int i = 0; i < N_CH; i++) begin
            drop_sum = drop_sum + (DROP_W+1)'(drop_vec[i]);
        end
        if (clr) begin
            drop_cnt_d = '0;
        end else if (drop_sum[DROP_W]) begin
            drop_cnt_d = '1;
        end else begin
            drop_cnt_d = drop_sum[DROP_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule
